led_sequencer: RTL and testbench

Controller that sequences the 6 on-board LEDs of the Tang Nano 9K through selectable display modes: binary count, bouncing scan, blink, and off. A prescaler generates a slow tick that paces pattern updates. A debounced push button advances the mode. The block sits between the board clock/button pins and the LED pins and replaces the free-running counter as the LED driver.

---
 rtl/led_seq_pkg.sv | 31 +++
 rtl/led_seq_btn_debounce.sv | 43 ++++
 rtl/led_sequencer.sv | 115 +++++++++++
 tb/tb_led_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared mode encodings and LED constants for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_OFF   = 2'd3
  } mode_t;

  localparam int N_LED = 6;
  localparam logic [N_LED-1:0] LED_ALL_OFF = 6'b111111;

  // LEDs are active-low, so the drive value is the inverted lit pattern.
  function automatic logic [N_LED-1:0] pattern_led(
    input mode_t            m,
    input logic [N_LED-1:0] count,
    input logic [2:0]       pos,
    input logic             phase
  );
    logic [N_LED-1:0] one;
    one = 6'd1;
    case (m)
      MODE_COUNT: pattern_led = ~count;
      MODE_SCAN:  pattern_led = ~(one << pos);
      MODE_BLINK: pattern_led = phase ? 6'b000000 : LED_ALL_OFF;
      default:    pattern_led = LED_ALL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse on an accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        // only the falling (pressed) transition is an event
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Mode FSM, prescaler and pattern generator driving the six active-low LEDs.
//   state      | meaning
//   MODE_COUNT | binary count on the LEDs
//   MODE_SCAN  | single lit LED bouncing end to end
//   MODE_BLINK | all LEDs toggle each tick
//   MODE_OFF   | all LEDs dark, ticks ignored
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV        = 13_500_000,
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic             press;
  mode_t            state_q, state_d;
  logic [N_LED-1:0] count_q, count_d;
  logic [2:0]       pos_q, pos_d;
  logic             dir_up_q, dir_up_d;
  logic             phase_q, phase_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_d;
  logic [N_LED-1:0] led_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .press (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MODE_COUNT;
      count_q  <= '0;
      pos_q    <= '0;
      dir_up_q <= 1'b1;
      phase_q  <= 1'b0;
      presc_q  <= '0;
      tick     <= 1'b0;
      led      <= LED_ALL_OFF;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
      phase_q  <= phase_d;
      presc_q  <= presc_d;
      tick     <= tick_d;
      led      <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    phase_d  = phase_q;
    presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

    // a press restarts the pattern and the prescaler; a coincident tick is dropped
    if (press) begin
      case (state_q)
        MODE_COUNT: state_d = MODE_SCAN;
        MODE_SCAN:  state_d = MODE_BLINK;
        MODE_BLINK: state_d = MODE_OFF;
        default:    state_d = MODE_COUNT;
      endcase
      count_d  = '0;
      pos_d    = '0;
      dir_up_d = 1'b1;
      phase_d  = 1'b0;
      presc_d  = '0;
    end else if (tick) begin
      case (state_q)
        MODE_COUNT: count_d = count_q + 6'd1;
        MODE_SCAN: begin
          if (dir_up_q) begin
            if (pos_q == 3'd5) begin
              dir_up_d = 1'b0;
              pos_d    = 3'd4;
            end else begin
              pos_d = pos_q + 3'd1;
            end
          end else begin
            if (pos_q == 3'd0) begin
              dir_up_d = 1'b1;
              pos_d    = 3'd1;
            end else begin
              pos_d = pos_q - 3'd1;
            end
          end
        end
        MODE_BLINK: phase_d = ~phase_q;
        default: ;
      endcase
    end

    tick_d = (presc_d == PRESC_LAST);
    led_d  = pattern_led(state_d, count_d, pos_d, phase_d);
  end

  assign mode = state_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with TICK_DIV=4 and DEBOUNCE_CYCLES=8.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic [5:0] led;
  logic [1:0] mode;
  logic       tick;

  always #5 clk = ~clk;

  led_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .led   (led),
    .mode  (mode),
    .tick  (tick)
  );

  typedef struct {
    int              len;
    logic            adv;
    logic [1:0]      exp_mode;
    logic [5:0]      exp_led;
    int              nseq;
    logic [0:9][5:0] seq;
  } press_vec_t;

  press_vec_t vecs [5];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_mchg = 0;
  logic       last_tick = 1'b0;
  logic [1:0] last_mode = 2'd0;
  logic [5:0] step_q [$];
  logic [5:0] pend_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", nm);
  endtask

  // One clock; a tick seen last cycle means this edge stepped the pattern,
  // unless the mode changed, in which case the new mode's expectations load.
  task automatic cycle();
    logic [5:0] e;
    @(negedge clk);
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL watchdog actual=%0d expected<=20000", cyc);
      $fatal(1);
    end
    if (mode != last_mode) begin
      n_mchg++;
      step_q = pend_q;
      pend_q.delete();
    end else if (last_tick && step_q.size() > 0) begin
      e = step_q.pop_front();
      chk("step_led", {26'd0, led}, {26'd0, e});
    end
    last_tick = tick;
    last_mode = mode;
  endtask

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while (step_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (step_q.size() > 0) timeout(nm);
  endtask

  task automatic wait_led(input logic [5:0] v, input logic [1:0] m, input int budget, input string nm);
    int n = 0;
    while (!(led == v && mode == m) && n < budget) begin
      cycle();
      n++;
    end
    if (!(led == v && mode == m)) timeout(nm);
  endtask

  task automatic do_press(input int idx);
    int chg;
    int m0;
    chg = -1;
    m0  = n_mchg;
    pend_q.delete();
    for (int j = 0; j < vecs[idx].nseq; j++) pend_q.push_back(vecs[idx].seq[j]);
    btn_n = 1'b0;
    for (int k = 1; k <= vecs[idx].len; k++) begin
      cycle();
      if (chg < 0 && n_mchg != m0) begin
        chg = k;
        chk($sformatf("vec%0d_mode", idx), {30'd0, mode}, {30'd0, vecs[idx].exp_mode});
        chk($sformatf("vec%0d_led", idx), {26'd0, led}, {26'd0, vecs[idx].exp_led});
      end
    end
    btn_n = 1'b1;
    repeat (16) cycle();
    chk($sformatf("vec%0d_advances", idx), n_mchg - m0, {31'd0, vecs[idx].adv});
    if (chg >= 0)
      chk($sformatf("vec%0d_latency_in_8_12 (lat=%0d)", idx, chg), {31'd0, (chg >= 8 && chg <= 12)}, 32'd1);
    else
      chk($sformatf("vec%0d_mode_held", idx), {30'd0, mode}, {30'd0, vecs[idx].exp_mode});
    drain(200, $sformatf("vec%0d_drain", idx));
  endtask

  initial begin
    int n;
    int chg;
    int gap;
    int m0;
    logic prev_tick;
    logic [5:0] v;

    vecs[0] = '{len: 20, adv: 1'b1, exp_mode: 2'd1, exp_led: 6'b111110, nseq: 8,
                seq: {6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111,
                      6'b101111, 6'b110111, 6'b111011, 6'b0, 6'b0}};
    vecs[1] = '{len: 5, adv: 1'b0, exp_mode: 2'd1, exp_led: 6'b111110, nseq: 0, seq: '0};
    vecs[2] = '{len: 200, adv: 1'b1, exp_mode: 2'd2, exp_led: 6'b111111, nseq: 8,
                seq: {6'b000000, 6'b111111, 6'b000000, 6'b111111, 6'b000000,
                      6'b111111, 6'b000000, 6'b111111, 6'b0, 6'b0}};
    vecs[3] = '{len: 20, adv: 1'b1, exp_mode: 2'd3, exp_led: 6'b111111, nseq: 10,
                seq: {10{6'b111111}}};
    vecs[4] = '{len: 20, adv: 1'b1, exp_mode: 2'd0, exp_led: 6'b111111, nseq: 5,
                seq: {6'b111110, 6'b111101, 6'b111100, 6'b111011, 6'b111010,
                      6'b0, 6'b0, 6'b0, 6'b0, 6'b0}};

    rst_n = 1'b0;
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_led", {26'd0, led}, 32'h3f);
    chk("reset_mode", {30'd0, mode}, 32'd0);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;

    // COUNT runs through a full 64-step wrap
    for (int i = 1; i <= 64; i++) begin
      v = 6'(i);
      step_q.push_back(~v);
    end
    drain(300, "count_wrap");
    chk("count_wrapped_led", {26'd0, led}, 32'h3f);

    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (tick) n++;
    end
    chk("tick_rate_per_40", n, 32'd10);

    for (int i = 0; i < 5; i++) do_press(i);

    // press pulse lands on the tick cycle at count=5: tick must be dropped
    wait_led(6'b111100, 2'd0, 400, "t5_wait_count3");
    cycle();
    pend_q = '{6'b111101, 6'b111011};
    btn_n = 1'b0;
    m0 = n_mchg;
    chg = -1;
    gap = -1;
    for (int k = 1; k <= 20; k++) begin
      prev_tick = tick;
      if (k == 11) chk("t5_pre_led", {26'd0, led}, {26'd0, 6'b111010});
      cycle();
      if (chg < 0 && n_mchg != m0) begin
        chg = k;
        chk("t5_tick_aligned", {31'd0, prev_tick}, 32'd1);
        chk("t5_led", {26'd0, led}, {26'd0, 6'b111110});
        chk("t5_mode", {30'd0, mode}, 32'd1);
      end else if (chg > 0 && gap < 0 && tick) begin
        gap = k - chg + 1;
      end
    end
    btn_n = 1'b1;
    chk("t5_next_tick_gap", gap, 32'd4);
    repeat (16) cycle();
    drain(100, "t5_drain");

    // asynchronous reset mid-scan
    wait_led(6'b110111, 2'd1, 100, "t6_wait_pos3");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_led", {26'd0, led}, 32'h3f);
    chk("t6_mode", {30'd0, mode}, 32'd0);
    chk("t6_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pend_q.delete();
    step_q = '{6'b111110, 6'b111101, 6'b111100};
    last_tick = 1'b0;
    last_mode = 2'd0;
    chk("t6_release_led", {26'd0, led}, 32'h3f);
    drain(100, "t6_count_restart");
    chk("t6_final_mode", {30'd0, mode}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
